// File: rtl/easyaxi_rd_mst.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : easyaxi_rd_mst
//  Brief    : Simple AXI read master. Issues REQ_NUM single-outstanding read
//             bursts (burst i: id=i, len=i, addr=ADDR_BASE+i*ADDR_STEP),
//             accepts all R beats and reports beat count, last data and
//             sticky response / rlast protocol error flags.
//  Revision : 1.0  initial release
// ============================================================================

`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 16
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif
`ifndef AXI_RESP_OK
`define AXI_RESP_OK 2'b00
`endif

module easyaxi_rd_mst #(
  parameter int unsigned                  REQ_NUM   = 4,
  parameter logic [`AXI_ADDR_W-1:0]       ADDR_BASE = 16'h0000,
  parameter logic [`AXI_ADDR_W-1:0]       ADDR_STEP = 16'h0010,
  parameter logic [`AXI_SIZE_W-1:0]       SIZE_VAL  = 3'd2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  output logic                    axi_mst_arvalid,
  input  logic                    axi_mst_arready,
  output logic [`AXI_ID_W-1:0]    axi_mst_arid,
  output logic [`AXI_ADDR_W-1:0]  axi_mst_araddr,
  output logic [`AXI_LEN_W-1:0]   axi_mst_arlen,
  output logic [`AXI_SIZE_W-1:0]  axi_mst_arsize,
  output logic [`AXI_BURST_W-1:0] axi_mst_arburst,
  input  logic                    axi_mst_rvalid,
  output logic                    axi_mst_rready,
  input  logic [`AXI_DATA_W-1:0]  axi_mst_rdata,
  input  logic [`AXI_RESP_W-1:0]  axi_mst_rresp,
  input  logic                    axi_mst_rlast,
  output logic                    done,
  output logic                    err_resp,
  output logic                    err_last,
  output logic [15:0]             beat_cnt,
  output logic [`AXI_DATA_W-1:0]  last_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Index of the final burst of a run (REQ_NUM is at most 16).
  localparam logic [4:0]             c_last_idx   = 5'(REQ_NUM - 1);
  localparam logic [`AXI_BURST_W-1:0] c_burst_incr = 2'b01;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [4:0]              r_req_idx;
  logic [15:0]             r_beat_idx;
  logic [15:0]             r_beat_cnt;
  logic                    r_err_resp;
  logic                    r_err_last;
  logic [`AXI_DATA_W-1:0]  r_last_rdata;

  logic                    w_start;
  logic                    w_ar_hs;
  logic                    w_r_hs;
  logic                    w_burst_end;
  logic                    w_final_burst;
  logic                    w_at_len;
  logic [`AXI_ID_W-1:0]    w_arid;
  logic [`AXI_ADDR_W-1:0]  w_araddr;
  logic [`AXI_LEN_W-1:0]   w_arlen;

  // Handshake qualifiers: R beats only count while the FSM is in R.
  assign w_start       = (r_state == S_IDLE) && enable;
  assign w_ar_hs       = (r_state == S_AR) && axi_mst_arready;
  assign w_r_hs        = (r_state == S_R) && axi_mst_rvalid;
  assign w_burst_end   = w_r_hs && axi_mst_rlast;
  assign w_final_burst = (r_req_idx == c_last_idx);

  // AR payload is a pure function of the burst index, so it is stable for
  // as long as the FSM waits in AR for arready.
  assign w_arid   = `AXI_ID_W'(r_req_idx);
  assign w_arlen  = `AXI_LEN_W'(r_req_idx);
  assign w_araddr = ADDR_BASE + (`AXI_ADDR_W'(r_req_idx) * ADDR_STEP);
  assign w_at_len = (r_beat_idx == 16'(w_arlen));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; enable is only looked at in IDLE and DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (enable) w_state_nxt = S_AR;
      end
      S_AR: begin
        if (w_ar_hs) w_state_nxt = S_R;
      end
      S_R: begin
        if (w_burst_end) w_state_nxt = w_final_burst ? S_DONE : S_AR;
      end
      S_DONE: begin
        if (!enable) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Burst/beat bookkeeping, counters, captured data and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_idx    <= '0;
      r_beat_idx   <= '0;
      r_beat_cnt   <= '0;
      r_err_resp   <= 1'b0;
      r_err_last   <= 1'b0;
      r_last_rdata <= '0;
    end else begin
      if (w_start) begin
        r_req_idx  <= '0;
        r_beat_idx <= '0;
        r_beat_cnt <= '0;
        r_err_resp <= 1'b0;
        r_err_last <= 1'b0;
      end
      if (w_r_hs) begin
        if (r_beat_cnt != 16'hFFFF) r_beat_cnt <= r_beat_cnt + 16'd1;
        r_last_rdata <= axi_mst_rdata;
        if (axi_mst_rresp != `AXI_RESP_OK) r_err_resp <= 1'b1;
        // Early rlast (index != arlen) or missing rlast (index == arlen).
        if (axi_mst_rlast != w_at_len) r_err_last <= 1'b1;
        if (axi_mst_rlast) begin
          r_beat_idx <= '0;
          if (!w_final_burst) r_req_idx <= r_req_idx + 5'd1;
        end else begin
          r_beat_idx <= r_beat_idx + 16'd1;
        end
      end
    end
  end

  // Output drive: payload is zero outside AR so reset and idle look clean.
  always_comb begin
    axi_mst_arvalid = (r_state == S_AR);
    axi_mst_arid    = '0;
    axi_mst_araddr  = '0;
    axi_mst_arlen   = '0;
    axi_mst_arsize  = '0;
    axi_mst_arburst = '0;
    if (r_state == S_AR) begin
      axi_mst_arid    = w_arid;
      axi_mst_araddr  = w_araddr;
      axi_mst_arlen   = w_arlen;
      axi_mst_arsize  = SIZE_VAL;
      axi_mst_arburst = c_burst_incr;
    end
    axi_mst_rready = (r_state == S_R);
    done           = (r_state == S_DONE);
    err_resp       = r_err_resp;
    err_last       = r_err_last;
    beat_cnt       = r_beat_cnt;
    last_rdata     = r_last_rdata;
  end

endmodule

`default_nettype wire

// File: tb/tb_easyaxi_rd_mst.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_easyaxi_rd_mst
//  Brief    : Self-checking bench for easyaxi_rd_mst with a sequential AXI
//             read slave and a burst-level reference model.
//  Revision : 1.0  initial release
// ============================================================================

`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 16
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

module tb_easyaxi_rd_mst;

    localparam int N = 4;
    localparam int c_timeout_ns = 1000000;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    enable;
    logic                    arvalid;
    logic                    arready;
    logic [`AXI_ID_W-1:0]    arid;
    logic [`AXI_ADDR_W-1:0]  araddr;
    logic [`AXI_LEN_W-1:0]   arlen;
    logic [`AXI_SIZE_W-1:0]  arsize;
    logic [`AXI_BURST_W-1:0] arburst;
    logic                    rvalid;
    logic                    rready;
    logic [`AXI_DATA_W-1:0]  rdata;
    logic [`AXI_RESP_W-1:0]  rresp;
    logic                    rlast;
    logic                    done;
    logic                    err_resp;
    logic                    err_last;
    logic [15:0]             beat_cnt;
    logic [`AXI_DATA_W-1:0]  last_rdata;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0]            m_beat_cnt;
    logic [`AXI_DATA_W-1:0] m_last_rdata;
    logic                   m_err_resp;
    logic                   m_err_last;

    easyaxi_rd_mst dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .axi_mst_arvalid (arvalid),
        .axi_mst_arready (arready),
        .axi_mst_arid    (arid),
        .axi_mst_araddr  (araddr),
        .axi_mst_arlen   (arlen),
        .axi_mst_arsize  (arsize),
        .axi_mst_arburst (arburst),
        .axi_mst_rvalid  (rvalid),
        .axi_mst_rready  (rready),
        .axi_mst_rdata   (rdata),
        .axi_mst_rresp   (rresp),
        .axi_mst_rlast   (rlast),
        .done            (done),
        .err_resp        (err_resp),
        .err_last        (err_last),
        .beat_cnt        (beat_cnt),
        .last_rdata      (last_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #(c_timeout_ns);
        n_errors++;
        $error("FAIL timeout: run did not finish within %0d ns", c_timeout_ns);
        $finish;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [`AXI_ADDR_W-1:0] exp_addr(input int i);
        int a;
        a = 0 + i * 16;
        return `AXI_ADDR_W'(a % 65536);
    endfunction

    task automatic ar_phase(input int i, input int stall);
        chk("ar_valid_rise", arvalid, 1'b1);
        chk("ar_id", arid, `AXI_ID_W'(i));
        chk("ar_addr", araddr, exp_addr(i));
        chk("ar_len", arlen, `AXI_LEN_W'(i));
        chk("ar_size", arsize, 3'd2);
        chk("ar_burst", arburst, 2'b01);
        chk("ar_rready_low", rready, 1'b0);
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            chk("ar_hold_valid", arvalid, 1'b1);
            chk("ar_hold_addr", araddr, exp_addr(i));
            chk("ar_hold_len", arlen, `AXI_LEN_W'(i));
        end
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        chk("ar_valid_drop", arvalid, 1'b0);
        chk("r_rready_rise", rready, 1'b1);
    endtask

    task automatic r_beat(input logic [1:0] resp, input bit last);
        int unsigned gap;
        logic [`AXI_DATA_W-1:0] d;
        gap = $urandom_range(0, 2);
        for (int k = 0; k < int'(gap); k++) begin
            @(negedge clk);
            chk("r_rready_hold", rready, 1'b1);
        end
        d      = $urandom;
        rvalid = 1'b1;
        rdata  = d;
        rresp  = resp;
        rlast  = last;
        chk("r_rready", rready, 1'b1);
        @(negedge clk);
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
        if (m_beat_cnt != 16'hFFFF) m_beat_cnt = m_beat_cnt + 16'd1;
        m_last_rdata = d;
        if (resp != 2'b00) m_err_resp = 1'b1;
    endtask

    task automatic r_burst(input int i, input int rl_beat, input bit decerr);
        for (int b = 0; b <= rl_beat; b++) begin
            r_beat((decerr && b == 0) ? 2'b11 : 2'b00, b == rl_beat);
        end
        if (rl_beat != i) m_err_last = 1'b1;
        chk("burst_beat_cnt", beat_cnt, m_beat_cnt);
        chk("burst_last_rdata", last_rdata, m_last_rdata);
        chk("burst_err_resp", err_resp, m_err_resp);
        chk("burst_err_last", err_last, m_err_last);
    endtask

    task automatic run(input int stall_b, input int stall_n, input int decerr_b,
                       input int rl_b, input int rl_beat, input int drop_b);
        enable     = 1'b1;
        m_beat_cnt = 16'd0;
        m_err_resp = 1'b0;
        m_err_last = 1'b0;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (i == drop_b) enable = 1'b0;
            ar_phase(i, (i == stall_b) ? stall_n : int'($urandom_range(0, 1)));
            r_burst(i, (i == rl_b) ? rl_beat : i, i == decerr_b);
        end
        chk("done_rise", done, 1'b1);
        chk("done_arvalid", arvalid, 1'b0);
        chk("done_rready", rready, 1'b0);
        chk("done_beat_cnt", beat_cnt, m_beat_cnt);
        chk("done_err_resp", err_resp, m_err_resp);
        chk("done_err_last", err_last, m_err_last);
        if (enable) begin
            repeat (3) begin
                @(negedge clk);
                chk("done_hold", done, 1'b1);
            end
            enable = 1'b0;
        end
        @(negedge clk);
        chk("done_fall", done, 1'b0);
        chk("idle_arvalid", arvalid, 1'b0);
    endtask

    task automatic check_zero();
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_rready", rready, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err_resp", err_resp, 1'b0);
        chk("rst_err_last", err_last, 1'b0);
        chk("rst_beat_cnt", beat_cnt, 16'd0);
        chk("rst_last_rdata", last_rdata, 32'd0);
        chk("rst_arid", arid, 4'd0);
        chk("rst_araddr", araddr, 16'd0);
        chk("rst_arlen", arlen, 8'd0);
        chk("rst_arsize", arsize, 3'd0);
        chk("rst_arburst", arburst, 2'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        enable  = 1'b0;
        arready = 1'b0;
        rvalid  = 1'b0;
        rdata   = '0;
        rresp   = 2'b00;
        rlast   = 1'b0;
        m_beat_cnt   = 16'd0;
        m_last_rdata = '0;
        m_err_resp   = 1'b0;
        m_err_last   = 1'b0;
        repeat (2) @(negedge clk);
        check_zero();
        rst_n = 1'b1;
        @(negedge clk);

        run(-1, 0, -1, -1, 0, -1);
        chk("s1_beat_cnt", beat_cnt, 16'd10);
        chk("s1_err_resp", err_resp, 1'b0);
        chk("s1_err_last", err_last, 1'b0);

        run(2, 5, -1, -1, 0, -1);
        chk("s2_beat_cnt", beat_cnt, 16'd10);

        run(-1, 0, 1, -1, 0, -1);
        chk("s3_beat_cnt", beat_cnt, 16'd10);
        chk("s3_err_resp", err_resp, 1'b1);

        run(-1, 0, -1, 2, 1, -1);
        chk("s4_beat_cnt", beat_cnt, 16'd9);
        chk("s4_err_last", err_last, 1'b1);

        run(-1, 0, -1, 1, 3, -1);
        chk("s4b_beat_cnt", beat_cnt, 16'd12);
        chk("s4b_err_last", err_last, 1'b1);

        enable     = 1'b1;
        m_beat_cnt = 16'd0;
        m_err_resp = 1'b0;
        m_err_last = 1'b0;
        @(negedge clk);
        ar_phase(0, 0);
        r_burst(0, 0, 1'b0);
        ar_phase(1, 0);
        r_burst(1, 1, 1'b0);
        ar_phase(2, 1);
        r_beat(2'b00, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero();
        enable       = 1'b0;
        m_last_rdata = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", arvalid, 1'b0);
        run(-1, 0, -1, -1, 0, -1);
        chk("s5_beat_cnt", beat_cnt, 16'd10);

        rvalid = 1'b1;
        rdata  = $urandom;
        rlast  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_rv_beat_cnt", beat_cnt, m_beat_cnt);
            chk("idle_rv_last_rdata", last_rdata, m_last_rdata);
            chk("idle_rv_rready", rready, 1'b0);
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        run(-1, 0, -1, -1, 0, 1);
        chk("s6_beat_cnt", beat_cnt, 16'd10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
